// File: rtl/interp_engine.sv
// Linear interpolation between bracketing BRAM samples:
//   y = y0 + (y1 - y0) * frac / STEP, truncated toward zero.
// A single restoring divider first splits x into (i, frac), then scales the slope product.
`timescale 1ns/1ps
module interp_engine #(
  parameter int unsigned STEP      = 10,
  parameter int unsigned N_SAMPLES = 1001
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [13:0]        x_in,
  output logic               busy,
  output logic               done,
  output logic signed [15:0] result,
  output logic               out_of_range,
  output logic [9:0]         rd_addr,
  input  logic signed [15:0] rd_data
);

  localparam int unsigned XW   = 14;                 // x / quotient width
  localparam int unsigned AW   = 10;                 // BRAM address width
  localparam int unsigned DW   = 30;                 // shared dividend width
  localparam int unsigned CW   = 5;                  // iteration counter width
  localparam int unsigned SW   = $clog2(STEP + 1);   // bits needed to hold STEP
  localparam int unsigned RW   = SW + 1;             // remainder register width
  localparam int unsigned LAST = N_SAMPLES - 1;      // last valid table index
  localparam int unsigned XMAX = LAST * STEP;        // largest in-range x

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DIV_X = 3'd1;
  localparam logic [2:0] S_RD0   = 3'd2;
  localparam logic [2:0] S_RD1   = 3'd3;
  localparam logic [2:0] S_RD2   = 3'd4;
  localparam logic [2:0] S_MUL   = 3'd5;
  localparam logic [2:0] S_DIV_P = 3'd6;
  localparam logic [2:0] S_FIN   = 3'd7;

  logic [2:0]          state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic signed [15:0]  result_q, result_d;
  logic                oor_q, oor_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                wt_q, wt_d;
  logic [DW-1:0]       dvd_q, dvd_d;
  logic [RW-1:0]       rem_q, rem_d;
  logic [RW-1:0]       frac_q, frac_d;
  logic                clamp_q, clamp_d;
  logic                oorp_q, oorp_d;
  logic signed [15:0]  y0_q, y0_d;
  logic signed [15:0]  y1_q, y1_d;
  logic                neg_q, neg_d;

  // Datapath intermediates
  logic [RW-1:0]       trial;
  logic                ge;
  logic [RW-1:0]       step_rem;
  logic [DW-1:0]       step_dvd;
  logic signed [16:0]  diff;
  logic signed [15:0]  frac_s;
  logic signed [30:0]  prod;
  logic [DW-1:0]       prod_mag;
  logic signed [17:0]  qs;

  assign busy         = busy_q;
  assign done         = done_q;
  assign result       = result_q;
  assign out_of_range = oor_q;
  assign rd_addr      = addr_q;

  // Next-state, divider step and interpolation arithmetic
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    oor_d    = oor_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    wt_d     = wt_q;
    dvd_d    = dvd_q;
    rem_d    = rem_q;
    frac_d   = frac_q;
    clamp_d  = clamp_q;
    oorp_d   = oorp_q;
    y0_d     = y0_q;
    y1_d     = y1_q;
    neg_d    = neg_q;

    // One restoring step: bring in dividend MSB, subtract STEP if it fits
    trial    = {rem_q[SW-1:0], dvd_q[DW-1]};
    ge       = (trial >= RW'(STEP));
    step_rem = ge ? RW'(trial - RW'(STEP)) : trial;
    step_dvd = {dvd_q[DW-2:0], ge};

    diff     = 17'(y1_q) - 17'(y0_q);
    frac_s   = signed'({1'b0, 15'(frac_q)});
    prod     = 31'(diff) * 31'(frac_s);
    prod_mag = prod[30] ? DW'(-prod) : DW'(prod);

    qs = signed'({1'b0, dvd_q[16:0]});
    if (neg_q) qs = -qs;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d  = 1'b1;
          dvd_d   = {x_in, (DW-XW)'(0)};
          rem_d   = '0;
          cnt_d   = CW'(XW - 1);
          clamp_d = 1'b0;
          oorp_d  = (32'(x_in) > XMAX);
          state_d = S_DIV_X;
        end
      end
      S_DIV_X: begin
        dvd_d = step_dvd;
        rem_d = step_rem;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = S_RD0;
      end
      S_RD0: begin
        frac_d = rem_q;
        if (32'(dvd_q[XW-1:0]) >= LAST) begin
          clamp_d = 1'b1;
          addr_d  = AW'(LAST);
        end else begin
          addr_d  = AW'(dvd_q[XW-1:0]);
        end
        wt_d    = 1'b0;
        state_d = S_RD1;
      end
      S_RD1: begin
        // First cycle lets the BRAM register the address; second captures y0
        if (!wt_q) begin
          wt_d = 1'b1;
        end else begin
          y0_d = rd_data;
          if ((frac_q == '0) || clamp_q) begin
            result_d = rd_data;
            oor_d    = oorp_q;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = S_IDLE;
          end else begin
            addr_d  = addr_q + AW'(1);
            wt_d    = 1'b0;
            state_d = S_RD2;
          end
        end
      end
      S_RD2: begin
        if (!wt_q) begin
          wt_d = 1'b1;
        end else begin
          y1_d    = rd_data;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        dvd_d   = prod_mag;
        neg_d   = prod[30];
        rem_d   = '0;
        cnt_d   = CW'(DW - 1);
        state_d = S_DIV_P;
      end
      S_DIV_P: begin
        dvd_d = step_dvd;
        rem_d = step_rem;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = S_FIN;
      end
      S_FIN: begin
        // Result lies between y0 and y1 so the 16-bit truncation is exact
        result_d = 16'(18'(y0_q) + qs);
        oor_d    = 1'b0;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      oor_q    <= 1'b0;
      addr_q   <= '0;
      cnt_q    <= '0;
      wt_q     <= 1'b0;
      dvd_q    <= '0;
      rem_q    <= '0;
      frac_q   <= '0;
      clamp_q  <= 1'b0;
      oorp_q   <= 1'b0;
      y0_q     <= '0;
      y1_q     <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      oor_q    <= oor_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      wt_q     <= wt_d;
      dvd_q    <= dvd_d;
      rem_q    <= rem_d;
      frac_q   <= frac_d;
      clamp_q  <= clamp_d;
      oorp_q   <= oorp_d;
      y0_q     <= y0_d;
      y1_q     <= y1_d;
      neg_q    <= neg_d;
    end
  end

endmodule

// File: tb/tb_interp_engine.sv
// Scoreboard bench for interp_engine with a 1-cycle-latency BRAM model.
`timescale 1ns/1ps
module tb_interp_engine;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [13:0]        x_in;
  logic               busy;
  logic               done;
  logic signed [15:0] result;
  logic               out_of_range;
  logic [9:0]         rd_addr;
  logic signed [15:0] rd_data;

  logic signed [15:0] mem [0:1023];

  typedef struct {
    int res;
    int oor;
    int addr;
    int cyc;
  } exp_t;

  exp_t sbq [$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  bit   pend_pulse = 1'b0;

  interp_engine #(.STEP(10), .N_SAMPLES(1001)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .x_in         (x_in),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .out_of_range (out_of_range),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // BRAM: data for the address seen at an edge appears after that edge
  always @(posedge clk) rd_data <= mem[rd_addr];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per done pulse
  always @(negedge clk) begin
    if (reset) begin
      pend_pulse = 1'b0;
    end else begin
      if (pend_pulse) chk("done_pulse_width", int'(done), 0);
      pend_pulse = done;
      if (done) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", int'(done), 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("result", int'(result), e.res);
          chk("out_of_range", int'(out_of_range), e.oor);
          chk("rd_addr", int'(rd_addr), e.addr);
          chk("done_cycle", cyc, e.cyc);
          chk("busy_at_done", int'(busy), 0);
        end
      end
    end
  end

  // Called at a negedge: issue start, push expectation with absolute done cycle
  task automatic issue(input int x, input int res, input int oor, input int addr, input int lat);
    exp_t e;
    start = 1'b1;
    x_in  = 14'(x);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    e.res  = res;
    e.oor  = oor;
    e.addr = addr;
    e.cyc  = cyc + lat;
    sbq.push_back(e);
    chk("busy_after_accept", int'(busy), 1);
  endtask

  // Returns at the negedge where done is seen; bounded
  task automatic wait_done();
    int got;
    got = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        break;
      end
    end
    if (got == 0) chk("done_timeout", got, 1);
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = 16'sd0;
    mem[0]    = 16'sd1234;
    mem[1]    = 16'sd100;
    mem[2]    = 16'sd200;
    mem[3]    = 16'sd100;
    mem[4]    = -16'sd3;
    mem[999]  = 16'sd0;
    mem[1000] = 16'sd1000;

    reset = 1'b1;
    start = 1'b0;
    x_in  = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_oor", int'(out_of_range), 0);
    chk("rst_rd_addr", int'(rd_addr), 0);
    reset = 1'b0;
    @(negedge clk);

    // Fast path, slopes, table ends
    issue(0, 1234, 0, 0, 17);       wait_done();
    @(negedge clk);
    issue(15, 150, 0, 2, 51);       wait_done();
    @(negedge clk);
    issue(37, 28, 0, 4, 51);        wait_done();
    @(negedge clk);
    issue(9999, 900, 0, 1000, 51);  wait_done();
    @(negedge clk);
    issue(10000, 1000, 0, 1000, 17); wait_done();
    @(negedge clk);
    issue(12000, 1000, 1, 1000, 17); wait_done();
    @(negedge clk);
    chk("oor_held", int'(out_of_range), 1);
    chk("rd_addr_held", int'(rd_addr), 1000);

    // Start during busy is ignored
    issue(15, 150, 0, 2, 51);
    repeat (5) @(negedge clk);
    start = 1'b1;
    x_in  = 14'd37;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (60) @(negedge clk);
    chk("no_queued_job", sbq.size(), 0);

    // Back-to-back: start driven for the edge right after done
    issue(37, 28, 0, 4, 51);        wait_done();
    issue(0, 1234, 0, 0, 17);       wait_done();
    issue(15, 150, 0, 2, 51);       wait_done();
    @(negedge clk);

    // Reset at E30 of a slow-path job
    start = 1'b1;
    x_in  = 14'd37;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (30) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_result", int'(result), 0);
    chk("midrst_oor", int'(out_of_range), 0);
    chk("midrst_rd_addr", int'(rd_addr), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    chk("midrst_no_done_pending", sbq.size(), 0);
    issue(37, 28, 0, 4, 51);        wait_done();
    repeat (3) @(negedge clk);
    chk("final_queue_empty", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/interp_engine.md
Name: interp_engine

Overview:
- Linear-interpolation datapath started by the top-level FSM in its busy state.
- Takes the user-selected x (0..9999 from the button/seven-segment selector) and reads the two bracketing samples from the input-points BRAM. It returns y = y0 + (y1-y0)*frac/STEP.
- Pulses done back to the FSM when the result is ready.
- Uses one shared sequential restoring divider for both divisions. No DSP/IP cores.

Parameters:
- STEP, 10, x-units between consecutive table samples. Range 2..16383.
- N_SAMPLES, 1001, number of valid samples in BRAM at addresses 0..N_SAMPLES-1. Must be ≤1024.

Ports:
- clk  in  1  system clock (100 MHz)
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; sampled only when idle
- x_in  in  14  unsigned x to interpolate at; latched on accepted start
- busy  out  1  high from the accepting edge until the done edge
- done  out  1  one-cycle pulse; result valid from this edge on
- result  out  16  signed interpolated y; held until the next done
- out_of_range  out  1  set with done when x_in > (N_SAMPLES-1)*STEP; held until the next done
- rd_addr  out  10  registered BRAM read address
- rd_data  in  16  signed BRAM read data; valid the edge after rd_addr changes (1-cycle latency, port always enabled)

Behaviour:
- Reset (asynchronous): state IDLE; busy, done, out_of_range, result, rd_addr all 0; internal registers cleared. Reset mid-operation abandons the computation with no done pulse.
- States: IDLE, DIV_X, RD0, RD1, RD2, MUL, DIV_P, FIN.
- Edge numbering is from E0, the edge that samples start=1 in IDLE.
- E0: latch x_in; busy<=1; enter DIV_X. start while busy is ignored (not queued).
- DIV_X, E1..E14: 14 restoring-division iterations of x by STEP → i = x/STEP, frac = x%STEP.
- RD0, E15: if i ≥ N_SAMPLES-1, rd_addr<=N_SAMPLES-1 and clamp flag set (out_of_range only if x > (N_SAMPLES-1)*STEP); else rd_addr<=i.
- RD1, E16: BRAM presents y[rd_addr]. E17: y0<=rd_data.
- Fast path at E17: if frac==0 or clamp is set, result<=rd_data, done<=1, busy<=0, return to IDLE. Latency 17.
- Otherwise at E17: rd_addr<=i+1.
- RD2, E19: y1<=rd_data.
- MUL, E20: diff = y1-y0 as 17-bit signed; product = diff*frac as signed 31-bit. Store |product| (30 bits) and its sign.
- DIV_P, E21..E50: 30 iterations dividing |product| by STEP → q_mag. q = sign ? -q_mag : q_mag, i.e. truncation toward zero.
- FIN, E51: result<=y0+q (always fits 16 bits because it lies between y0 and y1); done<=1; busy<=0; back to IDLE. Latency 51.
- done is a single-cycle pulse, deasserted the edge after it asserts.
- start is accepted on the same edge that leaves FIN/fast-path? No: it is accepted only in IDLE, i.e. from the cycle after done.
- rd_addr holds its last value while idle.
- Divider: shift-subtract restoring, one bit per cycle, MSB first; the shared remainder register is STEP-width + 1 bits.

Test Plan:
- Fast path: y[0]=1234, x_in=0, start → rd_addr 0; done at E17; result=1234; out_of_range=0; busy high E0..E17.
- Positive slope: y[1]=100, y[2]=200, x_in=15 → rd_addr 1 then 2; done at E51; result=150.
- Negative slope truncation: y[3]=100, y[4]=-3, x_in=37 → diff=-103, product=-721, q=-72; result=28 at E51.
- Table ends: x_in=9999 with y[999]=0, y[1000]=1000 → result=900, out_of_range=0. x_in=10000 → clamp fast path, result=y[1000], out_of_range=0. x_in=12000 → rd_addr=1000, result=y[1000], out_of_range=1, done at E17.
- Handshake: second start pulses during busy → ignored, exactly one done. Back-to-back starts issued in the cycle after done → both serviced with correct results.
- Reset mid-op: assert reset at E30 of a slow-path job → all outputs 0 immediately, no done. A new start after release completes normally.
